// File: rtl/booth4_mac_pipe_pkg.sv
// Shared types and helpers for the radix-4 Booth multiply-accumulate core.
package booth4_pkg;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M2,
        M1
    } booth_digit_t;

    // Number of Booth rows for a W-bit multiplier once it is extended to W+2
    // bits: ceil((W+2)/2).
    function automatic int npp(input int w);
        return (w + 3) / 2;
    endfunction

    // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] triplet);
        booth_digit_t digit;
        case (triplet)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth4_pp_row.sv
// One Booth partial-product row: selects 0/A/2A, conditionally inverts it and
// positions it at weight 4^i. A negative row is returned as its one's
// complement plus a hot bit that the caller injects at weight 2^SHIFT.
module booth4_pp_row
    import booth4_pkg::*;
#(
    parameter int W     = 24,
    parameter int SHIFT = 0
) (
    input  logic [W+1:0]   a,
    input  logic [2:0]     triplet,
    input  logic           sub,
    output logic [2*W-1:0] row,
    output logic           hot
);

    booth_digit_t   digit;
    logic [2*W-1:0] a_wide;
    logic [2*W-1:0] mag;
    logic           digit_neg;
    logic           row_neg;

    assign digit  = booth_decode(triplet);
    assign a_wide = {{(W - 2){a[W+1]}}, a};

    // Select the magnitude and sign; subtraction flips every non-zero digit,
    // so the negated product costs no extra adder.
    always_comb begin
        mag       = '0;
        digit_neg = 1'b0;
        row_neg   = 1'b0;
        row       = '0;
        hot       = 1'b0;
        case (digit)
            P1:      mag = a_wide;
            P2:      mag = a_wide << 1;
            M2:      begin mag = a_wide << 1; digit_neg = 1'b1; end
            M1:      begin mag = a_wide;      digit_neg = 1'b1; end
            default: mag = '0;
        endcase
        if (digit != ZERO) begin
            row_neg = digit_neg ^ sub;
            row     = (row_neg ? ~mag : mag) << SHIFT;
            hot     = row_neg;
        end
    end

endmodule

// File: rtl/booth4_mac_pipe.sv
// Three-stage elastic radix-4 Booth MAC: P = +/-(A*B) + C mod 2^(2W).
// S1 holds Booth rows + hot bits + C, S2 holds the CSA sum/carry pair,
// S3 holds the carry-propagated result.
module booth4_mac_pipe
    import booth4_pkg::*;
#(
    parameter int W     = 24,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2*W-1:0]   in_c,
    input  logic             in_signed,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NPP  = npp(W);
    localparam int NOPS = NPP + 2;
    localparam int PW   = 2 * W;

    logic             load1, load2, load3;
    logic [W+1:0]     a_ext;
    logic [2*NPP:0]   b_trip;
    logic [PW-1:0]    pp_next [NPP];
    logic [NPP-1:0]   hot_bits;
    logic [PW-1:0]    hot_next;

    logic             v1_reg, v2_reg, v3_reg;
    logic [PW-1:0]    pp_reg [NPP];
    logic [PW-1:0]    hot_reg, c1_reg;
    logic [TAG_W-1:0] tag1_reg, tag2_reg, tag3_reg;
    logic [PW-1:0]    sum_next, carry_next, sum2_reg, carry2_reg;
    logic [PW-1:0]    p_next, p3_reg;
    logic             zero3_reg;

    // A stage advances when it is empty or its successor is advancing.
    assign load3    = !v3_reg || out_ready;
    assign load2    = !v2_reg || load3;
    assign load1    = !v1_reg || load2;
    assign in_ready = load1;

    // Operand extension; b_trip[0] is the implicit b[-1] = 0.
    assign a_ext  = {{2{in_signed & in_a[W-1]}}, in_a};
    assign b_trip = {{(2 * NPP - W){in_signed & in_b[W-1]}}, in_b, 1'b0};

    generate
        for (genvar gi = 0; gi < NPP; gi++) begin : g_row
            booth4_pp_row #(.W(W), .SHIFT(2 * gi)) u_row (
                .a       (a_ext),
                .triplet (b_trip[2*gi+2:2*gi]),
                .sub     (in_sub),
                .row     (pp_next[gi]),
                .hot     (hot_bits[gi])
            );
        end
    endgenerate

    // Hot bits sit at distinct even weights, so they pack into one operand.
    always_comb begin
        hot_next = '0;
        for (int i = 0; i < NPP; i++) hot_next[2*i] = hot_bits[i];
    end

    // S1 occupancy.
    always_ff @(posedge clk) begin
        if (rst) v1_reg <= 1'b0;
        else if (load1) v1_reg <= in_valid;
    end

    // S1 payload, captured only on an input transfer.
    always_ff @(posedge clk) begin
        if (load1 && in_valid) begin
            for (int i = 0; i < NPP; i++) pp_reg[i] <= pp_next[i];
            hot_reg  <= hot_next;
            c1_reg   <= in_c;
            tag1_reg <= in_tag;
        end
    end

    // Wallace-style reduction: each level compresses groups of three operands
    // with 3:2 counters until only a sum/carry pair remains.
    always_comb begin
        logic [PW-1:0] tree [NOPS];
        logic [PW-1:0] x, y, z;
        int n, m;
        x = '0; y = '0; z = '0;
        n = NOPS; m = 0;
        for (int k = 0; k < NPP; k++) tree[k] = pp_reg[k];
        tree[NPP]     = hot_reg;
        tree[NPP + 1] = c1_reg;
        for (int lvl = 0; lvl < NOPS; lvl++) begin
            if (n > 2) begin
                m = 0;
                for (int j = 0; j < NOPS; j += 3) begin
                    if (j + 2 < n) begin
                        x = tree[j]; y = tree[j + 1]; z = tree[j + 2];
                        tree[m]     = x ^ y ^ z;
                        tree[m + 1] = ((x & y) | (x & z) | (y & z)) << 1;
                        m = m + 2;
                    end else if (j < n) begin
                        tree[m] = tree[j];
                        if (j + 1 < n) tree[m + 1] = tree[j + 1];
                        m = m + (n - j);
                    end
                end
                n = m;
            end
        end
        sum_next   = tree[0];
        carry_next = tree[1];
    end

    // S2 occupancy.
    always_ff @(posedge clk) begin
        if (rst) v2_reg <= 1'b0;
        else if (load2) v2_reg <= v1_reg;
    end

    // S2 payload: redundant sum/carry pair.
    always_ff @(posedge clk) begin
        if (load2 && v1_reg) begin
            sum2_reg   <= sum_next;
            carry2_reg <= carry_next;
            tag2_reg   <= tag1_reg;
        end
    end

    assign p_next = sum2_reg + carry2_reg;

    // S3: final carry-propagate result, held stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_reg    <= 1'b0;
            p3_reg    <= '0;
            zero3_reg <= 1'b0;
            tag3_reg  <= '0;
        end else if (load3) begin
            v3_reg <= v2_reg;
            if (v2_reg) begin
                p3_reg    <= p_next;
                zero3_reg <= (p_next == '0);
                tag3_reg  <= tag2_reg;
            end
        end
    end

    assign out_valid = v3_reg;
    assign out_p     = p3_reg;
    assign out_zero  = zero3_reg;
    assign out_tag   = tag3_reg;

endmodule

// File: tb/tb_booth4_mac_pipe.sv
// Bench for booth4_mac_pipe: three instances (W=24, 23, 8) share control so
// their pipelines move in lockstep; results are checked against an
// arithmetic reference model held in a scoreboard queue.
module tb_booth4_mac_pipe;

    logic clk = 1'b0;
    logic rst, in_valid, in_signed, in_sub, out_ready;
    logic [3:0] in_tag;
    logic [23:0] a24, b24; logic [47:0] c24;
    logic [22:0] a23, b23; logic [45:0] c23;
    logic [7:0]  a8,  b8;  logic [15:0] c8;
    logic ir24, ir23, ir8, ov24, ov23, ov8, z24, z23, z8;
    logic [47:0] p24; logic [45:0] p23; logic [15:0] p8;
    logic [3:0] t24, t23, t8;

    always #5 clk = ~clk;

    booth4_mac_pipe #(.W(24), .TAG_W(4)) dut24 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir24),
        .in_a(a24), .in_b(b24), .in_c(c24), .in_signed(in_signed), .in_sub(in_sub),
        .in_tag(in_tag), .out_valid(ov24), .out_ready(out_ready), .out_p(p24),
        .out_zero(z24), .out_tag(t24));
    booth4_mac_pipe #(.W(23), .TAG_W(4)) dut23 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir23),
        .in_a(a23), .in_b(b23), .in_c(c23), .in_signed(in_signed), .in_sub(in_sub),
        .in_tag(in_tag), .out_valid(ov23), .out_ready(out_ready), .out_p(p23),
        .out_zero(z23), .out_tag(t23));
    booth4_mac_pipe #(.W(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .in_c(c8), .in_signed(in_signed), .in_sub(in_sub),
        .in_tag(in_tag), .out_valid(ov8), .out_ready(out_ready), .out_p(p8),
        .out_zero(z8), .out_tag(t8));

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] e24, e23, e8;
    } exp_t;

    exp_t sbq[$];
    int n_vec = 0, n_err = 0, n_out = 0;
    logic prev_stall = 1'b0;
    logic [47:0] prev_p;
    logic [3:0] prev_t;
    logic prev_z;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // +/-(A*B)+C mod 2^(2w) with plain integer arithmetic.
    function automatic logic [63:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic sgn, input logic sub);
        longint sa, sbv, prod;
        logic [63:0] mask;
        sa   = (sgn && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sbv  = (sgn && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
        prod = sa * sbv;
        if (sub) prod = -prod;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return (64'(prod) + c) & mask;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        int r;
        mask = (64'd1 << w) - 64'd1;
        r = $urandom_range(0, 9);
        if (r == 0) return 64'd0;
        if (r == 1) return mask;
        if (r == 2) return 64'd1 << (w - 1);
        return {$urandom, $urandom} & mask;
    endfunction

    function automatic logic [63:0] pickc(input int w);
        if ($urandom_range(0, 4) == 0) return 64'd0;
        return {$urandom, $urandom} & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic set_all(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        a24 = a[23:0]; b24 = b[23:0]; c24 = c[47:0];
        a23 = a[22:0]; b23 = b[22:0]; c23 = c[45:0];
        a8  = a[7:0];  b8  = b[7:0];  c8  = c[15:0];
    endtask

    task automatic set_rand();
        logic [63:0] v;
        v = pick(24);  a24 = v[23:0];
        v = pick(24);  b24 = v[23:0];
        v = pickc(24); c24 = v[47:0];
        v = pick(23);  a23 = v[22:0];
        v = pick(23);  b23 = v[22:0];
        v = pickc(23); c23 = v[45:0];
        v = pick(8);   a8  = v[7:0];
        v = pick(8);   b8  = v[7:0];
        v = pickc(8);  c8  = v[15:0];
    endtask

    // One clock: score transfers seen before the edge, then advance to the
    // next falling edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (prev_stall) begin
            chk("stall_valid", 64'(ov24), 64'd1);
            chk("stall_p", 64'(p24), 64'(prev_p));
            chk("stall_tag", 64'(t24), 64'(prev_t));
            chk("stall_zero", 64'(z24), 64'(prev_z));
        end
        if (in_valid && ir24 && !rst) begin
            e.tag = in_tag;
            e.e24 = model(24, 64'(a24), 64'(b24), 64'(c24), in_signed, in_sub);
            e.e23 = model(23, 64'(a23), 64'(b23), 64'(c23), in_signed, in_sub);
            e.e8  = model(8,  64'(a8),  64'(b8),  64'(c8),  in_signed, in_sub);
            sbq.push_back(e);
        end
        if (ov24 && out_ready && !rst) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 64'(ov24), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("p24", 64'(p24), e.e24);
                chk("p23", 64'(p23), e.e23);
                chk("p8", 64'(p8), e.e8);
                chk("zero24", 64'(z24), 64'(e.e24 == 64'd0));
                chk("zero8", 64'(z8), 64'(e.e8 == 64'd0));
                chk("tag", 64'(t24), 64'(e.tag));
                $display("out tag=%0d p24=%h p23=%h p8=%h", t24, p24, p23, p8);
                n_out++;
            end
        end
        prev_stall = ov24 && !out_ready && !rst;
        prev_p = p24; prev_t = t24; prev_z = z24;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single directed op on an idle pipe with latency and value checks.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic sgn, input logic sub, input logic [3:0] tag,
                         input logic [63:0] exp_p, input logic exp_z);
        int lat, guard;
        set_all(a, b, c);
        in_signed = sgn; in_sub = sub; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        guard = 0; #1;
        while (!ir24 && guard < 10) begin cycle(); guard++; #1; end
        cycle();
        in_valid = 1'b0;
        lat = 1; #1;
        while (!ov24 && lat < 10) begin cycle(); lat++; #1; end
        chk("latency", 64'(lat), 64'd3);
        chk("dir_p", 64'(p24), exp_p);
        chk("dir_zero", 64'(z24), 64'(exp_z));
        chk("dir_tag", 64'(t24), 64'(tag));
        cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, base, stale, issued;
        logic saw_low, fire;

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_signed = 1'b0; in_sub = 1'b0; in_tag = 4'd0;
        set_all(64'd0, 64'd0, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(ov24), 64'd0);
        chk("rst_out_p", 64'(p24), 64'd0);
        chk("rst_out_zero", 64'(z24), 64'd0);
        chk("rst_out_tag", 64'(t24), 64'd0);
        chk("rst_in_ready", 64'(ir24), 64'd1);
        @(negedge clk);

        // Directed corners.
        do_op(64'hFFFFFF, 64'hFFFFFF, 64'd0, 1'b0, 1'b0, 4'd1, 64'hFFFFFE000001, 1'b0);
        do_op(64'hFFFFFF, 64'hFFFFFF, 64'd0, 1'b1, 1'b0, 4'd2, 64'd1, 1'b0);
        do_op(64'h800000, 64'h800000, 64'd0, 1'b1, 1'b0, 4'd3, 64'h400000000000, 1'b0);
        do_op(64'd3, 64'd5, 64'd20, 1'b0, 1'b1, 4'd4, 64'd5, 1'b0);
        do_op(64'd4, 64'd5, 64'd20, 1'b0, 1'b1, 4'd5, 64'd0, 1'b1);
        do_op(64'd0, 64'h123456, 64'hABC, 1'b1, 1'b0, 4'd6, 64'hABC, 1'b0);
        do_op(64'h654321, 64'd0, 64'h77, 1'b1, 1'b1, 4'd7, 64'h77, 1'b0);
        do_op(64'h800000, 64'h000001, 64'd0, 1'b1, 1'b1, 4'd8, 64'h000000800000, 1'b0);

        // Backpressure: tags 0..7 back-to-back, out_ready low for cycles 2-8.
        sent = 0; base = n_out; saw_low = 1'b0;
        in_signed = 1'b1; in_sub = 1'b0;
        for (int cyc = 0; cyc < 40 && (n_out - base) < 8; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 8);
            in_valid = (sent < 8);
            set_rand();
            in_tag = 4'(sent);
            #1;
            fire = in_valid && ir24;
            if (in_valid && !ir24 && !saw_low) begin
                saw_low = 1'b1;
                chk("bp_occupancy", 64'(sbq.size()), 64'd3);
            end
            cycle();
            if (fire) sent++;
        end
        chk("bp_inready_low", 64'(saw_low), 64'd1);
        chk("bp_delivered", 64'(n_out - base), 64'd8);

        // Reset with three operations held in the pipe.
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_rand(); in_tag = 4'(8 + k); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        #1;
        chk("rst_mid_held", 64'(sbq.size()), 64'd3);
        chk("rst_mid_full", 64'(ir24), 64'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sbq.delete();
        prev_stall = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(ov24), 64'd0);
        chk("rst_mid_p", 64'(p24), 64'd0);
        out_ready = 1'b1; stale = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (ov24) stale++;
            cycle();
        end
        chk("rst_mid_stale", 64'(stale), 64'd0);
        do_op(64'd7, 64'd9, 64'd1, 1'b0, 1'b0, 4'd12, 64'd64, 1'b0);

        // Random regression with random backpressure.
        issued = 0;
        for (int cyc = 0; cyc < 3000 && issued < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            in_signed = 1'($urandom);
            in_sub    = 1'($urandom);
            in_tag    = 4'($urandom);
            set_rand();
            #1;
            fire = in_valid && ir24;
            cycle();
            if (fire) issued++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && sbq.size() > 0; k++) cycle();
        chk("drain_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
